// File: rtl/uart_rx_sis_if.sv
// Serial input and byte-delivery outputs of the UART1 receiver.
interface uart_rx_sis_if;
  logic       rx1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (input rx1, output data_out, data_valid, frame_err, parity_err, busy);
  modport slave  (output rx1, input data_out, data_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_sis.sv
// UART1 receiver: oversampled 8N1 deserializer on clk_sis with framing error flag.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_sis #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input logic            clk_sis,
  input logic            rst,
  uart_rx_sis_if.master  bus
);
  localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT/2 - 1);
  localparam logic [7:0] FULL_M1 = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_IDLE
  } state_t;

  state_t                 state, state_n;
  logic [1:0]             sync;
  logic                   rx_s;
  logic [7:0]             cnt, cnt_n;
  logic [2:0]             bit_idx, bit_n;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   sample_data, ok, ferr;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit, sample_par, perr;
`endif

  assign rx_s     = sync[1];
  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      sync           <= 2'b11;
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      bus.data_out   <= 8'h00;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      sync           <= {sync[0], bus.rx1};
      state          <= state_n;
      cnt            <= cnt_n;
      bit_idx        <= bit_n;
      if (sample_data) shift_reg[bit_idx] <= rx_s;
      // Pulses register at the stop-bit sample edge; state is already back in IDLE.
      bus.data_valid <= ok;
      bus.frame_err  <= ferr;
      if (ok) bus.data_out <= shift_reg;
`ifdef UART_RX_PARITY_EN
      if (sample_par) par_bit <= rx_s;
      bus.parity_err <= perr;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign bus.parity_err = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 8'd1;
    bit_n       = bit_idx;
    sample_data = 1'b0;
    ok          = 1'b0;
    ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
    perr        = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        // Sync flops reset to 1 and IDLE is only entered with rx_s=1, so low here is a falling edge.
        if (!rx_s) begin
          state_n = START;
          bit_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n       = '0;
          sample_data = 1'b1;
          bit_n       = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_n      = '0;
          sample_par = 1'b1;
          state_n    = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bit == ^shift_reg) ok = 1'b1;
            else                       perr = 1'b1;
`else
            ok = 1'b1;
`endif
          end else begin
            ferr    = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_sis.sv
// Bench for uart_rx_sis: frame-level reference queue predicts every output pulse and data_out each cycle.
module tb_uart_rx_sis;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB/2 + 10*CPB + 1;
`else
  localparam int LAT = 2 + CPB/2 + 9*CPB + 1;
`endif

  logic clk_sis = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_sis = ~clk_sis;

  uart_rx_sis_if bus();
  uart_rx_sis #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (.clk_sis(clk_sis), .rst(rst), .bus(bus));

  typedef struct { int cyc; int kind; logic [7:0] data; } ev_t;
  ev_t q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int last_dv_cyc = -1;
  logic [7:0] last_dv_data = 8'h00;
  logic chk_en = 1'b0;
  logic prev_rst = 1'b1;
  logic [7:0] exp_dout = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_sis); #1; end
  endtask

  always @(posedge clk_sis) cyc <= cyc + 1;

  // Reference: each queued frame produces exactly one pulse LAT cycles after its start edge.
  always @(negedge clk_sis) begin
    logic exp_dv, exp_fe, exp_pe;
    ev_t e;
    exp_dv = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
    if (prev_rst) begin
      exp_dout = 8'h00;
      q.delete();
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      case (e.kind)
        0: begin exp_dv = 1'b1; exp_dout = e.data; end
        1: exp_fe = 1'b1;
        default: exp_pe = 1'b1;
      endcase
    end
    prev_rst = rst;
    if (chk_en) begin
      chk("data_valid", bus.data_valid, exp_dv);
      chk("frame_err", bus.frame_err, exp_fe);
      chk("parity_err", bus.parity_err, exp_pe);
      chk("data_out", bus.data_out, exp_dout);
      if (bus.data_valid === 1'b1) begin
        last_dv_cyc  = cyc;
        last_dv_data = bus.data_out;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip,
                      input int gap, input int abort_bit, input int tail_low, output int st);
    ev_t e;
    st = cyc;
    if (abort_bit < 0) begin
      e.cyc  = st + LAT;
      e.data = b;
      e.kind = !stop_v ? 1 : (par_flip ? 2 : 0);
      q.push_back(e);
    end
    bus.rx1 = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        rst = 1'b1; bus.rx1 = 1'b1; tick(3);
        rst = 1'b0; tick(CPB);
        return;
      end
      bus.rx1 = b[i];
      if (i == 0) chk("busy_mid", bus.busy, 1);
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx1 = (^b) ^ par_flip; tick(CPB);
`endif
    bus.rx1 = stop_v; tick(CPB);
    if (tail_low > 0) begin
      bus.rx1 = 1'b0; tick(tail_low*CPB);
      chk("busy_break", bus.busy, 1);
      bus.rx1 = 1'b1; tick(4);
      chk("busy_release", bus.busy, 0);
    end
    bus.rx1 = 1'b1; tick(gap*CPB);
  endtask

  initial begin
    int st, st2;
    logic [7:0] b;
    logic sb, pf;
    bus.rx1 = 1'b1;
    rst = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(100);
    chk("idle_busy", bus.busy, 0);
    chk("idle_dout", bus.data_out, 8'h00);

    last_dv_cyc = -1;
    send(8'h5B, 1'b1, 1'b0, 2, -1, 0, st);
`ifdef UART_RX_PARITY_EN
    chk("lat_5B", last_dv_cyc - st, 171);
`else
    chk("lat_5B", last_dv_cyc - st, 155);
`endif
    chk("byte_5B", last_dv_data, 8'h5B);

    send(8'h00, 1'b1, 1'b0, 0, -1, 0, st);
    chk("b2b_00", last_dv_data, 8'h00);
    send(8'hFF, 1'b1, 1'b0, 2, -1, 0, st2);
    chk("b2b_FF", last_dv_data, 8'hFF);
    chk("b2b_spacing", last_dv_cyc - st2, LAT);

    bus.rx1 = 1'b0; tick(3);
    bus.rx1 = 1'b1; tick(40);
    chk("glitch_busy", bus.busy, 0);

    send(8'hA5, 1'b0, 1'b0, 2, -1, 40, st);
    chk("break_keeps", bus.data_out, 8'hFF);

    send(8'h77, 1'b1, 1'b0, 0, 4, 0, st);
    chk("abort_dout", bus.data_out, 8'h00);
    send(8'h3C, 1'b1, 1'b0, 2, -1, 0, st);
    chk("after_abort", last_dv_data, 8'h3C);

`ifdef UART_RX_PARITY_EN
    send(8'h96, 1'b1, 1'b1, 2, -1, 0, st);
    chk("par_keeps", bus.data_out, 8'h3C);
`endif

    for (int n = 0; n < 30; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 4) == 0);
`else
      pf = 1'b0;
`endif
      send(b, sb, pf, sb ? $urandom_range(0, 3) : $urandom_range(1, 3), -1, 0, st);
    end

    tick(200);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_sis.md
Name: uart_rx_sis

Overview:
- UART receiver; the far end of the UART1 serial link. Deserializes the tx1 line back into bytes.
- Runs entirely on the system clock clk_sis and oversamples the incoming serial line.
- Framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); idle line is 1.
- Delivers each byte with a one-cycle valid pulse to downstream logic; flags framing errors.

Parameters:
- CLKS_PER_BIT, 16, clk_sis cycles per serial bit; legal range 4..255, must be even.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clk_sis  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx1  input  1  serial line from the transmitter; asynchronous to clk_sis.
- data_out  output  8  last correctly received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse; data_out is updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 without the macro.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the clk_sis edge.
  - Outputs: data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, busy=0.
  - State=IDLE, counters=0, both synchronizer flops=1.
  - Reset asserted mid-frame aborts the frame with no pulse; rx activity during reset is ignored.
- Input synchronization:
  - rx1 passes through a 2-flop synchronizer giving rx_s.
  - All decisions use rx_s, so there is 2 cycles of input latency.
- State machine:
  - IDLE: busy=0. A 1->0 transition on rx_s clears the bit counter, clears the cycle counter, and goes to START.
  - START: on cycle count CLKS_PER_BIT/2-1 (mid start bit):
    - rx_s=0: go to DATA and clear the cycle counter.
    - rx_s=1: glitch; return to IDLE silently with no pulse.
  - DATA: every CLKS_PER_BIT cycles (mid-bit) sample rx_s into shift_reg[bit_idx], bit_idx 0..7 (LSB first). After bit 7, go to STOP (or PARITY when the macro is defined).
  - STOP: at mid stop bit:
    - rx_s=1: next cycle data_out<=shift_reg, data_valid=1 for exactly 1 cycle, then IDLE.
    - rx_s=0: frame_err=1 for 1 cycle, data_out unchanged, then WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then IDLE. A held-low line (break) never produces a second error or any bytes.
- Timing:
  - Return to IDLE occurs at mid stop bit, so back-to-back frames (next start bit immediately after stop) are received without loss.
  - Latency from the rx1 falling edge of the start bit to the data_valid pulse = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (10*CLKS_PER_BIT with parity).
- Pulse rules:
  - data_valid and frame_err are never high in the same cycle.
  - Pulses are not held; a consumer that misses one loses the byte.
- Counters:
  - Cycle counter is 8 bits and resets to 0 on each sample point; no wrap is reachable.
  - bit_idx is 3 bits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; frame becomes 11 bits.
  - Even parity: the sampled parity bit must equal the XOR of the 8 data bits.
  - On mismatch, parity_err pulses 1 cycle at the same point data_valid would.
  - The byte is still discarded (no data_valid) and the FSM proceeds to STOP as normal.
  - If the stop bit is also 0, frame_err pulses and parity_err does not.
- Undefined:
  - No PARITY state; 10-bit frame.
  - parity_err is constant 0.

Test Plan:
- Reset, then rx1 idle high for 100 cycles -> all outputs 0, busy=0, data_out=8'h00.
- CLKS_PER_BIT=16, send 8'h5B framed correctly -> exactly one data_valid pulse with data_out=8'h5B, at 2+8+144+1=155 cycles after the start edge; frame_err=0.
- Send 8'h00 then 8'hFF back-to-back with no idle gap -> two data_valid pulses, data_out 8'h00 then 8'hFF, no errors.
- rx1 low pulse of 3 cycles on an idle line -> returns to IDLE, no pulses, data_out unchanged.
- Send 8'hA5 with stop bit forced 0 and the line held low 40 bit-times afterwards -> one frame_err pulse, no data_valid, data_out keeps its previous value, busy stays 1 until rx1 returns high.
- Assert rst at data bit 4 of a frame, release, then send 8'h3C -> no pulses for the aborted frame; 8'h3C received correctly. With UART_RX_PARITY_EN: a bad parity bit gives a parity_err pulse and no data_valid.
